dma_read_arbiter: RTL and testbench

DMA_READ_ARBITER -- requirements
Module: dma_read_arbiter

---
 rtl/dma_arb_pkg.sv | 8 +
 rtl/dma_req_slot.sv | 30 +++
 rtl/dma_read_arbiter.sv | 113 +++++++++++
 tb/tb_dma_read_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg: shared widths and FSM state for the two-channel DMA read arbiter
package dma_arb_pkg;
    localparam int ADDR_W   = 30;
    localparam int DATA_W   = 32;
    localparam int BEAT_W   = 8;
    localparam int STARVE_W = 4;
    typedef enum logic {IDLE, DATA} state_t;
endpackage

// File: rtl/dma_req_slot.sv
// dma_req_slot: per-channel request latch holding the pending flag and burst address
module dma_req_slot
    import dma_arb_pkg::*;
(
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              clr,
    output logic              pending,
    output logic [ADDR_W-1:0] addr_q,
    output logic              ready,
    output logic              err
);
    assign ready = ~pending;
    // a second start while a request is still outstanding is dropped, not queued
    assign err   = start & pending;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pending <= 1'b0;
            addr_q  <= '0;
        end else if (start && !pending) begin
            pending <= 1'b1;
            addr_q  <= addr;
        end else if (clr) begin
            pending <= 1'b0;
        end
    end
endmodule

// File: rtl/dma_read_arbiter.sv
// dma_read_arbiter: shares one DMA read engine between two requesters,
// channel 0 preferred with a starvation bound for channel 1.
module dma_read_arbiter
    import dma_arb_pkg::*;
#(
    parameter int BURST_SIZE = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              REQ0_START,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    output logic              REQ0_READY,
    output logic [DATA_W-1:0] REQ0_RD_DATA,
    output logic              REQ0_RD_DATA_VALID,
    input  logic              REQ1_START,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    output logic              REQ1_READY,
    output logic [DATA_W-1:0] REQ1_RD_DATA,
    output logic              REQ1_RD_DATA_VALID,
    output logic [ADDR_W-1:0] DMA_RD_ADDR,
    output logic              DMA_START,
    input  logic              DMA_READY,
    input  logic [DATA_W-1:0] DMA_RD_DATA,
    input  logic              DMA_RD_DATA_VALID,
    output logic              GRANT,
    output logic              BUSY,
    output logic              PROTOCOL_ERR
);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_SIZE - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(MAX_WAIT);

    state_t              state_q, state_d;
    logic [1:0]          pending;
    logic [ADDR_W-1:0]   addr0_q, addr1_q;
    logic                err0, err1, issue, win, last_beat, stray;
    logic [BEAT_W-1:0]   beat_q;
    logic [STARVE_W-1:0] starve_q;

    dma_req_slot u_slot0 (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .start   (REQ0_START),
        .addr    (REQ0_ADDR),
        .clr     (last_beat & ~GRANT),
        .pending (pending[0]),
        .addr_q  (addr0_q),
        .ready   (REQ0_READY),
        .err     (err0)
    );

    dma_req_slot u_slot1 (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .start   (REQ1_START),
        .addr    (REQ1_ADDR),
        .clr     (last_beat & GRANT),
        .pending (pending[1]),
        .addr_q  (addr1_q),
        .ready   (REQ1_READY),
        .err     (err1)
    );

    always_comb begin
        state_d   = state_q;
        win       = 1'b0;
        issue     = 1'b0;
        last_beat = 1'b0;
        stray     = 1'b0;
        win       = pending[1] && (!pending[0] || starve_q >= STARVE_LIM);
        issue     = state_q == IDLE && DMA_READY && |pending;
        last_beat = state_q == DATA && DMA_RD_DATA_VALID && beat_q == LAST_BEAT;
        stray     = state_q == IDLE && DMA_RD_DATA_VALID;
        state_d   = issue ? DATA : last_beat ? IDLE : state_q;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            DMA_START    <= 1'b0;
            DMA_RD_ADDR  <= '0;
            GRANT        <= 1'b0;
            beat_q       <= '0;
            starve_q     <= '0;
            PROTOCOL_ERR <= 1'b0;
        end else begin
            DMA_START    <= issue;
            PROTOCOL_ERR <= err0 | err1 | stray;
            if (issue) begin
                DMA_RD_ADDR <= win ? addr1_q : addr0_q;
                GRANT       <= win;
                beat_q      <= '0;
                // starvation only accrues while channel 1 is actually waiting
                if (win)
                    starve_q <= '0;
                else if (pending[1] && starve_q != '1)
                    starve_q <= starve_q + 1'b1;
            end else if (state_q == DATA && DMA_RD_DATA_VALID) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign BUSY               = state_q == DATA;
    assign REQ0_RD_DATA       = DMA_RD_DATA;
    assign REQ1_RD_DATA       = DMA_RD_DATA;
    assign REQ0_RD_DATA_VALID = BUSY & DMA_RD_DATA_VALID & ~GRANT;
    assign REQ1_RD_DATA_VALID = BUSY & DMA_RD_DATA_VALID & GRANT;
endmodule

// File: tb/tb_dma_read_arbiter.sv
// tb_dma_read_arbiter: table-driven vectors plus directed multi-cycle sequences
module tb_dma_read_arbiter;
    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        REQ0_START = 1'b0, REQ1_START = 1'b0;
    logic [29:0] REQ0_ADDR = '0, REQ1_ADDR = '0;
    logic        REQ0_READY, REQ1_READY;
    logic [31:0] REQ0_RD_DATA, REQ1_RD_DATA;
    logic        REQ0_RD_DATA_VALID, REQ1_RD_DATA_VALID;
    logic [29:0] DMA_RD_ADDR;
    logic        DMA_START;
    logic        DMA_READY = 1'b0;
    logic [31:0] DMA_RD_DATA = '0;
    logic        DMA_RD_DATA_VALID = 1'b0;
    logic        GRANT, BUSY, PROTOCOL_ERR;

    int nvec = 0;
    int nerr = 0;

    dma_read_arbiter #(.BURST_SIZE(8), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .REQ0_START(REQ0_START), .REQ0_ADDR(REQ0_ADDR), .REQ0_READY(REQ0_READY),
        .REQ0_RD_DATA(REQ0_RD_DATA), .REQ0_RD_DATA_VALID(REQ0_RD_DATA_VALID),
        .REQ1_START(REQ1_START), .REQ1_ADDR(REQ1_ADDR), .REQ1_READY(REQ1_READY),
        .REQ1_RD_DATA(REQ1_RD_DATA), .REQ1_RD_DATA_VALID(REQ1_RD_DATA_VALID),
        .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_START(DMA_START), .DMA_READY(DMA_READY),
        .DMA_RD_DATA(DMA_RD_DATA), .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID),
        .GRANT(GRANT), .BUSY(BUSY), .PROTOCOL_ERR(PROTOCOL_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic         s0;
        logic [29:0]  a0;
        logic         rdy;
        logic         vld;
        logic [31:0]  d;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [127:0] obs();
        return {26'd0, DMA_START, DMA_RD_ADDR, GRANT, BUSY, PROTOCOL_ERR,
                REQ0_RD_DATA_VALID, REQ1_RD_DATA_VALID, REQ0_READY, REQ1_READY,
                REQ0_RD_DATA, REQ1_RD_DATA};
    endfunction

    function automatic vec_t mk(logic s0, logic [29:0] a0, logic rdy, logic vld, logic [31:0] d,
                                logic e_start, logic [29:0] e_addr, logic e_busy,
                                logic e_err, logic e_v0, logic e_rdy0);
        vec_t v;
        v.s0 = s0; v.a0 = a0; v.rdy = rdy; v.vld = vld; v.d = d;
        v.exp = {26'd0, e_start, e_addr, 1'b0, e_busy, e_err, e_v0, 1'b0, e_rdy0, 1'b1, d, d};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        REQ0_START = 0; REQ1_START = 0; DMA_READY = 0; DMA_RD_DATA_VALID = 0; DMA_RD_DATA = '0;
        repeat (2) cyc();
        RESETN = 1'b1;
    endtask

    task automatic wait_start(input int max, output int lat, output logic g, output logic [29:0] a);
        lat = -1; g = 1'bx; a = 'x;
        for (int i = 0; i < max; i++) begin
            @(negedge CLK);
            if (DMA_START) begin
                lat = i; g = GRANT; a = DMA_RD_ADDR;
                cyc();
                return;
            end
            cyc();
        end
    endtask

    task automatic burst(input int n, output int c0, output int c1);
        c0 = 0; c1 = 0;
        for (int k = 0; k < n; k++) begin
            DMA_RD_DATA_VALID = 1'b1;
            DMA_RD_DATA = 32'hC0DE_0000 + k;
            @(negedge CLK);
            c0 += int'(REQ0_RD_DATA_VALID);
            c1 += int'(REQ1_RD_DATA_VALID);
            cyc();
        end
        DMA_RD_DATA_VALID = 1'b0;
    endtask

    initial begin
        int lat, c0, c1, errs, strobes, busy_cnt, seen;
        logic g;
        logic [29:0] a;

        // single channel-0 burst, stray beat in IDLE, double start while pending
        tbl.push_back(mk(1, 30'h100, 1, 0, 0,          0, 30'h000, 0, 0, 0, 1));
        tbl.push_back(mk(0, 30'h000, 1, 0, 0,          0, 30'h000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 30'h000, 1, 0, 0,          1, 30'h100, 1, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 30'h000, 1, 1, 32'hA0 + i, 0, 30'h100, 1, 0, 1, 0));
        tbl.push_back(mk(0, 30'h000, 1, 0, 0,          0, 30'h100, 0, 0, 0, 1));
        tbl.push_back(mk(0, 30'h000, 0, 1, 32'hDEAD,   0, 30'h100, 0, 0, 0, 1));
        tbl.push_back(mk(0, 30'h000, 0, 0, 0,          0, 30'h100, 0, 1, 0, 1));
        tbl.push_back(mk(0, 30'h000, 0, 0, 0,          0, 30'h100, 0, 0, 0, 1));
        tbl.push_back(mk(1, 30'h200, 0, 0, 0,          0, 30'h100, 0, 0, 0, 1));
        tbl.push_back(mk(1, 30'h300, 0, 0, 0,          0, 30'h100, 0, 0, 0, 0));
        tbl.push_back(mk(0, 30'h000, 0, 0, 0,          0, 30'h100, 0, 1, 0, 0));
        tbl.push_back(mk(0, 30'h000, 0, 0, 0,          0, 30'h100, 0, 0, 0, 0));
        tbl.push_back(mk(0, 30'h000, 1, 0, 0,          0, 30'h100, 0, 0, 0, 0));
        tbl.push_back(mk(0, 30'h000, 0, 0, 0,          1, 30'h200, 1, 0, 0, 0));

        RESETN = 1'b0;
        repeat (2) cyc();
        @(negedge CLK);
        chk("reset_state", obs(), {26'd0, 1'b0, 30'd0, 5'b0, 2'b11, 64'd0});
        cyc();
        RESETN = 1'b1;

        foreach (tbl[i]) begin
            REQ0_START = tbl[i].s0; REQ0_ADDR = tbl[i].a0; DMA_READY = tbl[i].rdy;
            DMA_RD_DATA_VALID = tbl[i].vld; DMA_RD_DATA = tbl[i].d;
            @(negedge CLK);
            chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
            cyc();
        end

        // simultaneous starts: channel 0 first, channel 1 two cycles after its last beat
        do_reset();
        DMA_READY = 1; REQ0_START = 1; REQ0_ADDR = 30'h10; REQ1_START = 1; REQ1_ADDR = 30'h20;
        cyc();
        REQ0_START = 0; REQ1_START = 0;
        @(negedge CLK);
        chk("both_latched", 128'({REQ0_READY, REQ1_READY}), 128'(0));
        cyc();
        wait_start(10, lat, g, a);
        chk("b_issue0", 128'({lat[7:0], g, a}), 128'({8'd0, 1'b0, 30'h10}));
        burst(8, c0, c1);
        chk("b_beats0", 128'({c0[7:0], c1[7:0]}), 128'({8'd8, 8'd0}));
        wait_start(10, lat, g, a);
        chk("b_issue1", 128'({lat[7:0], g, a}), 128'({8'd1, 1'b1, 30'h20}));
        burst(8, c0, c1);
        chk("b_beats1", 128'({c0[7:0], c1[7:0]}), 128'({8'd0, 8'd8}));
        @(negedge CLK);
        chk("b_ready1", 128'({REQ1_READY, BUSY}), 128'(2'b10));
        cyc();

        // DMA_READY low for 20 cycles with both pending
        do_reset();
        REQ0_START = 1; REQ0_ADDR = 30'h500; REQ1_START = 1; REQ1_ADDR = 30'h600;
        cyc();
        REQ0_START = 0; REQ1_START = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            seen += int'(DMA_START | BUSY);
            cyc();
        end
        chk("hold_no_start", 128'(seen), 128'(0));
        DMA_READY = 1;
        wait_start(10, lat, g, a);
        chk("ready_issue", 128'({lat[7:0], g, a}), 128'({8'd1, 1'b0, 30'h500}));

        // channel 0 keeps re-requesting while channel 1 waits
        do_reset();
        REQ0_START = 1; REQ0_ADDR = 30'h1000; REQ1_START = 1; REQ1_ADDR = 30'h2000;
        cyc();
        REQ0_START = 0; REQ1_START = 0; DMA_READY = 1;
        for (int i = 0; i < 5; i++) begin
            wait_start(10, lat, g, a);
            DMA_READY = 0;
            chk($sformatf("starve_issue%0d", i), 128'({lat[7:0], g, a}),
                128'({8'd1, i == 4, (i == 4) ? 30'h2000 : 30'h1000 + 30'(i)}));
            burst(8, c0, c1);
            if (i < 4) begin
                REQ0_START = 1; REQ0_ADDR = 30'h1000 + 30'(i + 1);
                cyc();
                REQ0_START = 0; DMA_READY = 1;
            end
        end
        REQ1_START = 1; REQ1_ADDR = 30'h2001;
        cyc();
        REQ1_START = 0; DMA_READY = 1;
        wait_start(10, lat, g, a);
        DMA_READY = 0;
        chk("starve_cleared", 128'({lat[7:0], g, a}), 128'({8'd1, 1'b0, 30'h1004}));

        // reset mid-burst, then stray beats
        do_reset();
        REQ0_START = 1; REQ0_ADDR = 30'h300;
        cyc();
        REQ0_START = 0; DMA_READY = 1;
        wait_start(10, lat, g, a);
        DMA_READY = 0;
        chk("rst_issue", 128'({lat[7:0], g, a}), 128'({8'd1, 1'b0, 30'h300}));
        burst(3, c0, c1);
        DMA_RD_DATA = '0;
        RESETN = 1'b0;
        #1;
        chk("rst_async", obs(), {26'd0, 1'b0, 30'd0, 5'b0, 2'b11, 64'd0});
        cyc();
        RESETN = 1'b1;
        errs = 0; strobes = 0; busy_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            DMA_RD_DATA_VALID = (k < 5);
            @(negedge CLK);
            errs += int'(PROTOCOL_ERR);
            strobes += int'(REQ0_RD_DATA_VALID | REQ1_RD_DATA_VALID);
            busy_cnt += int'(BUSY);
            cyc();
        end
        DMA_RD_DATA_VALID = 0;
        chk("stray_errs", 128'(errs), 128'(5));
        chk("stray_quiet", 128'({strobes[7:0], busy_cnt[7:0]}), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
